// File: rtl/seq_mult_sa.sv
// Sequential shift-add multiplier: WIDTH-bit operands, 2*WIDTH-bit product, unsigned or two's-complement per operation.
// Optional early exit when the remaining multiplier is zero: define SEQ_MULT_EARLY_EXIT_EN.
module seq_mult_sa #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 SIGNED_MODE,
  output logic [2*WIDTH-1:0]   P,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [1:0]           state_dbg
);

  // Handshake: START is accepted on any rising edge seen in IDLE; BUSY is high
  // from that edge until the result edge; DONE pulses for one cycle with P valid.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     mplier;
  logic [CNT_W-1:0]     cnt;
  logic                 neg;
  logic [2*WIDTH-1:0]   p_q;
  logic                 busy_q;
  logic                 done_q;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic                 last_iter;

  // The most-negative value negates to itself, which read unsigned is exactly 2^(W-1).
  assign abs_a = (SIGNED_MODE && A[WIDTH-1]) ? (~A + 1'b1) : A;
  assign abs_b = (SIGNED_MODE && B[WIDTH-1]) ? (~B + 1'b1) : B;

`ifdef SEQ_MULT_EARLY_EXIT_EN
  assign last_iter = (cnt == CNT_W'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (START) state_n = CALC;
      CALC:    if (last_iter) state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      p_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (START) begin
            neg    <= SIGNED_MODE & (A[WIDTH-1] ^ B[WIDTH-1]);
            mcand  <= {{WIDTH{1'b0}}, abs_a};
            mplier <= abs_b;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        FIN: begin
          p_q    <= neg ? (~acc + 1'b1) : acc;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign P         = p_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_seq_mult_sa.sv
// Self-checking bench for seq_mult_sa (WIDTH=8); expected latency follows SEQ_MULT_EARLY_EXIT_EN if defined.
module tb_seq_mult_sa;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           signed_mode;
  logic [2*W-1:0] p;
  logic           busy;
  logic           done;
  logic [1:0]     state_dbg;

  logic [2*W-1:0] exp_q[$];
  int             lat_q[$];
  int             tests;
  int             fails;

  seq_mult_sa #(.WIDTH(W)) dut (
    .CLK(clk), .RST(rst), .START(start), .A(a), .B(b),
    .SIGNED_MODE(signed_mode), .P(p), .BUSY(busy), .DONE(done),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic signed [W:0]     sx;
    logic signed [W:0]     sy;
    logic signed [2*W+1:0] full;
    sx   = s ? $signed({x[W-1], x}) : $signed({1'b0, x});
    sy   = s ? $signed({y[W-1], y}) : $signed({1'b0, y});
    full = sx * sy;
    return full[2*W-1:0];
  endfunction

  function automatic int model_lat(input logic [W-1:0] y, input logic s);
    int iters;
`ifdef SEQ_MULT_EARLY_EXIT_EN
    logic [W-1:0] m;
    m = (s && y[W-1]) ? (~y + 1'b1) : y;
    iters = 1;
    for (int i = 0; i < W; i++) if (m[i]) iters = i + 1;
`else
    iters = W;
`endif
    return iters + 2;
  endfunction

  // driver: called at a negedge; raises START with operands, optionally scoreboarding it
  task automatic drive_start(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input bit push);
    start = 1'b1; a = x; b = y; signed_mode = s;
    if (push) begin
      exp_q.push_back(model_prod(x, y, s));
      lat_q.push_back(model_lat(y, s));
    end
  endtask

  task automatic end_start();
    @(negedge clk);
    start = 1'b0;
    a = $urandom_range(0, 255); b = $urandom_range(0, 255); signed_mode = $urandom_range(0, 1);
  endtask

  // n0 = edges already seen since (and including) the accepting edge
  task automatic wait_done(input int n0);
    int n;
    logic [2*W-1:0] e;
    int el;
    n = n0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      tests++; fails++;
      $error("FAIL done_timeout observed=0 expected=1");
      void'(exp_q.pop_front()); void'(lat_q.pop_front());
      return;
    end
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    check("latency", n, el);
    check("product", {16'h0, p}, {16'h0, e});
    check("busy_at_done", {31'h0, busy}, 32'h0);
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [2*W-1:0] held;
    drive_start(x, y, s, 1'b1);
    end_start();
    check("busy_after_accept", {31'h0, busy}, 32'h1);
    wait_done(1);
    held = p;
    @(negedge clk);
    check("done_single_pulse", {31'h0, done}, 32'h0);
    check("p_hold", {16'h0, p}, {16'h0, held});
  endtask

  initial begin
    bit seen;
    tests = 0; fails = 0;
    start = 1'b0; a = '0; b = '0; signed_mode = 1'b0;

    // 1. reset then idle
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_p", {16'h0, p}, 32'h0);
      check("idle_busy_done", {30'h0, busy, done}, 32'h0);
    end

    // 2. unsigned max
    run_op(8'hFF, 8'hFF, 1'b0);
    check("fe01_const", {16'h0, p}, 32'hFE01);

    // 3. signed corners
    run_op(8'h80, 8'h7F, 1'b1);
    check("c080_const", {16'h0, p}, 32'hC080);
    run_op(8'h80, 8'h80, 1'b1);
    check("4000_const", {16'h0, p}, 32'h4000);
    run_op(8'hFD, 8'h05, 1'b1);
    check("fff1_const", {16'h0, p}, 32'hFFF1);

    // 4. START while busy ignored; START in DONE cycle accepted
    drive_start(8'h11, 8'h0D, 1'b0, 1'b1);
    end_start();
    @(negedge clk);
    @(negedge clk);
    drive_start(8'h02, 8'h02, 1'b0, 1'b0);
    end_start();
    check("busy_ignores_start", {31'h0, busy}, 32'h1);
    wait_done(4);
    drive_start(8'h0A, 8'h0C, 1'b0, 1'b1);
    end_start();
    check("done_cycle_accept_busy", {31'h0, busy}, 32'h1);
    wait_done(1);
    check("0078_const", {16'h0, p}, 32'h0078);
    @(negedge clk);

    // 5. reset mid-operation
    drive_start(8'h12, 8'h34, 1'b0, 1'b0);
    end_start();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_p", {16'h0, p}, 32'h0);
    check("abort_busy_done", {30'h0, busy, done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("no_done_after_abort", {31'h0, seen}, 32'h0);
    run_op(8'h03, 8'h07, 1'b0);
    check("0015_const", {16'h0, p}, 32'h0015);

    // 6. early-exit patterns (full latency expected when the feature is off)
    run_op(8'h55, 8'h01, 1'b0);
    run_op(8'h55, 8'h00, 1'b0);
    run_op(8'h55, 8'h80, 1'b0);
    check("2a80_const", {16'h0, p}, 32'h2A80);

    // random mixed-mode operations
    for (int i = 0; i < 12; i++)
      run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
